// File: rtl/alu_daa_seq.sv
// Nibble-serial decimal-adjust engine: low nibble in LOW, high nibble in HIGH.
// One 4-bit add/sub path per cycle; flags registered with the result.
module alu_daa_seq #(
    parameter bit PF_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a_in,
    input  logic       cf_in,
    input  logic       hf_in,
    input  logic       nf_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       cf_out,
    output logic       hf_out,
    output logic       sf_out,
    output logic       zf_out,
    output logic       pf_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic       cf_q, cf_d;
    logic       hf_q, hf_d;
    logic       nf_q, nf_d;
    logic       lgt9_q, lgt9_d;
    logic       hgt9_q, hgt9_d;
    logic       heq9_q, heq9_d;
    logic [3:0] lo_q, lo_d;
    logic       c4_q, c4_d;
    logic       hc_q, hc_d;
    logic [7:0] result_q, result_d;
    logic       cf_out_q, cf_out_d;
    logic       hf_out_q, hf_out_d;
    logic       sf_q, sf_d;
    logic       zf_q, zf_d;
    logic       pf_q, pf_d;
    logic       done_q, done_d;

    logic       lc;
    logic [4:0] adj_lo;
    logic [4:0] sum5;
    logic [3:0] adj_hi;
    logic [3:0] hi;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        cf_d     = cf_q;
        hf_d     = hf_q;
        nf_d     = nf_q;
        lgt9_d   = lgt9_q;
        hgt9_d   = hgt9_q;
        heq9_d   = heq9_q;
        lo_d     = lo_q;
        c4_d     = c4_q;
        hc_d     = hc_q;
        result_d = result_q;
        cf_out_d = cf_out_q;
        hf_out_d = hf_out_q;
        sf_d     = sf_q;
        zf_d     = zf_q;
        pf_d     = pf_q;
        done_d   = 1'b0;
        lc       = 1'b0;
        adj_lo   = 5'd0;
        sum5     = 5'd0;
        adj_hi   = 4'd0;
        hi       = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    cf_d    = cf_in;
                    hf_d    = hf_in;
                    nf_d    = nf_in;
                    lgt9_d  = a_in[3:0] > 4'd9;
                    hgt9_d  = a_in[7:4] > 4'd9;
                    heq9_d  = a_in[7:4] == 4'd9;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                lc     = hf_q | lgt9_q;
                adj_lo = lc ? 5'd6 : 5'd0;
                // bit 4 is carry after add, borrow after sub
                sum5   = nf_q ? ({1'b0, a_q[3:0]} - adj_lo)
                              : ({1'b0, a_q[3:0]} + adj_lo);
                lo_d    = sum5[3:0];
                c4_d    = sum5[4];
                hc_d    = cf_q | hgt9_q | (heq9_q & lgt9_q);
                state_d = S_HIGH;
            end
            S_HIGH: begin
                adj_hi = hc_q ? 4'd6 : 4'd0;
                hi     = nf_q ? (a_q[7:4] - adj_hi - {3'b000, c4_q})
                              : (a_q[7:4] + adj_hi + {3'b000, c4_q});
                result_d = {hi, lo_q};
                cf_out_d = hc_q;
                hf_out_d = nf_q ? (hf_q & (a_q[3:0] < 4'd6)) : lgt9_q;
                sf_d     = result_d[7];
                zf_d     = result_d == 8'h00;
                pf_d     = PF_EN ? ~^result_d : 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= 8'h00;
            cf_q     <= 1'b0;
            hf_q     <= 1'b0;
            nf_q     <= 1'b0;
            lgt9_q   <= 1'b0;
            hgt9_q   <= 1'b0;
            heq9_q   <= 1'b0;
            lo_q     <= 4'h0;
            c4_q     <= 1'b0;
            hc_q     <= 1'b0;
            result_q <= 8'h00;
            cf_out_q <= 1'b0;
            hf_out_q <= 1'b0;
            sf_q     <= 1'b0;
            zf_q     <= 1'b0;
            pf_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            cf_q     <= cf_d;
            hf_q     <= hf_d;
            nf_q     <= nf_d;
            lgt9_q   <= lgt9_d;
            hgt9_q   <= hgt9_d;
            heq9_q   <= heq9_d;
            lo_q     <= lo_d;
            c4_q     <= c4_d;
            hc_q     <= hc_d;
            result_q <= result_d;
            cf_out_q <= cf_out_d;
            hf_out_q <= hf_out_d;
            sf_q     <= sf_d;
            zf_q     <= zf_d;
            pf_q     <= pf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_LOW) || (state_q == S_HIGH);
    assign done   = done_q;
    assign result = result_q;
    assign cf_out = cf_out_q;
    assign hf_out = hf_out_q;
    assign sf_out = sf_q;
    assign zf_out = zf_q;
    assign pf_out = pf_q;

endmodule
